// File: rtl/posit_window_streamer.sv
// posit_window_streamer: ping-pong window buffer between two neuron layers.
// One bank fills from the upstream layer while the other replays its window
// downstream as a framed stream (sow on the first word, eow on the last).
//
// Bank state | meaning
// EMPTY      | no data; writes may start a new window
// FILLING    | window partially written; wcnt words stored
// FULL       | window complete (len valid); being or waiting to be replayed
module posit_window_streamer #(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_WORDS    = 784
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   rtr_o,
    input  logic                   rts_i,
    input  logic                   eow_i,
    input  logic [POSIT_WIDTH-1:0] posit_i,
    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [POSIT_WIDTH-1:0] posit_o
);

    localparam int CNT_W = $clog2(NB_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NB_WORDS - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    bank_state_t            state_q [2];
    bank_state_t            state_d [2];
    logic [CNT_W-1:0]       len_q   [2];
    logic [POSIT_WIDTH-1:0] mem     [2][NB_WORDS];

    logic             wbank_q;
    logic             rbank_q;
    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] rcnt_q;

    logic wr_fire;
    logic wr_close;
    logic rd_fire;
    logic rd_last;

    // Outputs depend only on registered state; rts_o never looks at rtr_i.
    assign rtr_o    = (state_q[wbank_q] != FULL);
    assign rts_o    = (state_q[rbank_q] == FULL);
    assign posit_o  = mem[rbank_q][rcnt_q];
    assign sow_o    = rts_o && (rcnt_q == '0);
    assign eow_o    = rts_o && (rcnt_q == (len_q[rbank_q] - ONE));

    assign wr_fire  = rts_i && rtr_o;
    assign rd_fire  = rts_o && rtr_i;
    assign rd_last  = rd_fire && eow_o;
    // A full bank closes the window even without eow_i.
    assign wr_close = eow_i || (wcnt_q == LAST_ADDR);

    // Next bank states; a write and a closing read never target the same bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
        end
        if (wr_fire) begin
            state_d[wbank_q] = wr_close ? FULL : FILLING;
        end
        if (rd_last) begin
            state_d[rbank_q] = EMPTY;
        end
    end

    // Bank state, pointers, counters and window lengths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            if (wr_fire) begin
                if (wr_close) begin
                    len_q[wbank_q] <= wcnt_q + ONE;
                    wcnt_q         <= '0;
                    wbank_q        <= ~wbank_q;
                end else begin
                    wcnt_q <= wcnt_q + ONE;
                end
            end
            if (rd_fire) begin
                if (eow_o) begin
                    rcnt_q  <= '0;
                    rbank_q <= ~rbank_q;
                end else begin
                    rcnt_q <= rcnt_q + ONE;
                end
            end
        end
    end

    // Window storage; contents survive reset, only the bank states are cleared.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wbank_q][wcnt_q] <= posit_i;
        end
    end

endmodule

// File: tb/tb_posit_window_streamer.sv
// Testbench for posit_window_streamer: scenario tasks with a scoreboard
// that models the block as an ordered list of completed windows.
module tb_posit_window_streamer;

   localparam int PW = 4;
   localparam int NB = 784;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rtr_o;
   logic          rts_i;
   logic          eow_i;
   logic [PW-1:0] posit_i;
   logic          rtr_i;
   logic          rts_o;
   logic          sow_o;
   logic          eow_o;
   logic [PW-1:0] posit_o;

   posit_window_streamer #(.POSIT_WIDTH(PW), .NB_WORDS(NB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rtr_o   (rtr_o),
      .rts_i   (rts_i),
      .eow_i   (eow_i),
      .posit_i (posit_i),
      .rtr_i   (rtr_i),
      .rts_o   (rts_o),
      .sow_o   (sow_o),
      .eow_o   (eow_o),
      .posit_o (posit_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [PW-1:0] in_word [$];
   bit            in_eow  [$];
   logic [PW-1:0] cur_q   [$];
   logic [PW-1:0] exp_word [$];
   bit            exp_sow  [$];
   bit            exp_eow  [$];
   int            full_windows;

   bit            prev_hold;
   logic [PW-1:0] prev_posit;
   logic          prev_sow;
   logic          prev_eow;
   int            cyc_total = 0;

   task automatic model_reset();
      in_word.delete();
      in_eow.delete();
      cur_q.delete();
      exp_word.delete();
      exp_sow.delete();
      exp_eow.delete();
      full_windows = 0;
      prev_hold    = 1'b0;
   endtask

   task automatic add_window(int len, bit eow_last, bit cyclic);
      for (int i = 0; i < len; i++) begin
         in_word.push_back(cyclic ? PW'(i % 16) : PW'($urandom));
         in_eow.push_back(eow_last && (i == len - 1));
      end
   endtask

   task automatic do_reset();
      rts_i   = 1'b0;
      eow_i   = 1'b0;
      rtr_i   = 1'b0;
      posit_i = '0;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(int rts_pct, int rtr_pct, int max_cycles, bit must_drain);
      int cyc = 0;
      bit wf, rf, e;
      while (cyc < max_cycles && (in_word.size() > 0 || exp_word.size() > 0)) begin
         if (in_word.size() > 0 && $urandom_range(0, 99) < rts_pct) begin
            rts_i   = 1'b1;
            posit_i = in_word[0];
            eow_i   = in_eow[0];
         end else begin
            rts_i   = 1'b0;
            posit_i = PW'($urandom);
            eow_i   = 1'($urandom);
         end
         rtr_i = ($urandom_range(0, 99) < rtr_pct);
         @(negedge clk);

         checks++;
         if (rtr_o !== (full_windows < 2)) begin
            errors++;
            $display("FAIL rtr_o t=%0t got=%b exp=%b", $time, rtr_o, full_windows < 2);
         end
         checks++;
         if (rts_o !== (full_windows > 0)) begin
            errors++;
            $display("FAIL rts_o t=%0t got=%b exp=%b", $time, rts_o, full_windows > 0);
         end
         if (full_windows > 0) begin
            checks++;
            if (posit_o !== exp_word[0] || sow_o !== exp_sow[0] || eow_o !== exp_eow[0]) begin
               errors++;
               $display("FAIL word t=%0t got=%h/sow%b/eow%b exp=%h/sow%b/eow%b",
                        $time, posit_o, sow_o, eow_o, exp_word[0], exp_sow[0], exp_eow[0]);
            end
         end else begin
            checks++;
            if (sow_o !== 1'b0 || eow_o !== 1'b0) begin
               errors++;
               $display("FAIL idle_flags t=%0t got sow=%b eow=%b exp 0/0", $time, sow_o, eow_o);
            end
         end
         if (prev_hold) begin
            checks++;
            if (posit_o !== prev_posit || sow_o !== prev_sow || eow_o !== prev_eow) begin
               errors++;
               $display("FAIL hold t=%0t got=%h/%b/%b exp=%h/%b/%b",
                        $time, posit_o, sow_o, eow_o, prev_posit, prev_sow, prev_eow);
            end
         end

         wf = rts_i && (full_windows < 2);
         rf = (full_windows > 0) && rtr_i;
         prev_hold  = (full_windows > 0) && !rtr_i;
         prev_posit = posit_o;
         prev_sow   = sow_o;
         prev_eow   = eow_o;

         if (rf) begin
            void'(exp_word.pop_front());
            void'(exp_sow.pop_front());
            e = exp_eow.pop_front();
            if (e) full_windows--;
         end
         if (wf) begin
            cur_q.push_back(in_word.pop_front());
            e = in_eow.pop_front();
            if (e || cur_q.size() == NB) begin
               for (int i = 0; i < cur_q.size(); i++) begin
                  exp_word.push_back(cur_q[i]);
                  exp_sow.push_back(i == 0);
                  exp_eow.push_back(i == cur_q.size() - 1);
               end
               cur_q.delete();
               full_windows++;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         cyc_total++;
      end
      rts_i = 1'b0;
      if (must_drain) begin
         checks++;
         if (in_word.size() != 0 || exp_word.size() != 0) begin
            errors++;
            $display("FAIL drain got in=%0d out=%0d pending exp 0/0", in_word.size(), exp_word.size());
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (rtr_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_rtr got=%b exp=1", rtr_o);
      end
      checks++;
      if (rts_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_rts got=%b exp=0", rts_o);
      end
      checks++;
      if (sow_o !== 1'b0 || eow_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b%b exp=00", sow_o, eow_o);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_window();
      add_window(NB, 1'b1, 1'b1);
      stream(100, 100, 2000, 1'b1);
   endtask

   task automatic test_back_to_back();
      in_word.push_back(4'hA); in_eow.push_back(1'b0);
      in_word.push_back(4'hB); in_eow.push_back(1'b0);
      in_word.push_back(4'hC); in_eow.push_back(1'b1);
      in_word.push_back(4'hD); in_eow.push_back(1'b1);
      stream(100, 100, 50, 1'b1);
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int w = 0; w < 3; w++) add_window(5, 1'b1, 1'b0);
      stream(100, 0, 20, 1'b0);
      @(negedge clk);
      checks++;
      if (rtr_o !== 1'b0) begin
         errors++;
         $display("FAIL both_full_rtr got=%b exp=0", rtr_o);
      end
      checks++;
      if (rts_o !== 1'b1 || sow_o !== 1'b1) begin
         errors++;
         $display("FAIL both_full_rts got=%b sow=%b exp=1/1", rts_o, sow_o);
      end
      @(posedge clk);
      #1;
      stream(100, 100, 100, 1'b1);
   endtask

   task automatic test_no_eow();
      add_window(NB, 1'b0, 1'b0);
      add_window(3, 1'b1, 1'b0);
      stream(100, 100, 2000, 1'b1);
   endtask

   task automatic test_random();
      int len;
      add_window(1, 1'b1, 1'b0);
      for (int w = 0; w < 199; w++) begin
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, NB) : $urandom_range(1, 20);
         add_window(len, (len == NB) ? 1'($urandom) : 1'b1, 1'b0);
      end
      stream(50, 50, 80000, 1'b1);
   endtask

   task automatic test_reset_mid();
      do_reset();
      add_window(10, 1'b1, 1'b0);
      stream(100, 0, 12, 1'b0);
      stream(0, 100, 4, 1'b0);
      rst_n = 1'b0;
      #2;
      checks++;
      if (rts_o !== 1'b0 || rtr_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got rts=%b rtr=%b exp 0/1", rts_o, rtr_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      checks++;
      if (rts_o !== 1'b0 || rtr_o !== 1'b1 || sow_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got rts=%b rtr=%b sow=%b exp 0/1/0", rts_o, rtr_o, sow_o);
      end
      @(posedge clk);
      #1;
      add_window(2, 1'b1, 1'b0);
      stream(100, 100, 20, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_full_window();
      test_back_to_back();
      test_backpressure();
      test_no_eow();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got t=%0t exp finish earlier", $time);
      $fatal(1, "timeout");
   end

endmodule
